// File: rtl/alu_pkg.sv
// Shared ALU operation codes, segment constants and width helpers for the
// ALU result display path.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int digit_idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/arithmetic_logic_unit.sv
// Combinational ALU: ADD/SUB/AND/ORR with N/Z/C/V flags.
// Carry on SUB is the inverted borrow (1 = no borrow).
module arithmetic_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // Operation select and flag generation.
    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result    = w_sum[WIDTH-1:0];
                carry_out = w_sum[WIDTH];
                overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result    = w_diff[WIDTH-1:0];
                carry_out = w_diff[WIDTH];
                overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: begin
                result = a & b;
            end
            ALU_ORR: begin
                result = a | b;
            end
            default: begin
                result = '0;
            end
        endcase
        negative = result[WIDTH-1];
        zero     = (result == '0);
    end

endmodule

// File: rtl/seg_digit_blanker.sv
// One display digit: decoded nibble, or all segments off when blanked.
module seg_digit_blanker
    import alu_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] w_decoded;

    seven_seg_decoder u_decoder (
        .nibble (nibble),
        .seg    (w_decoded)
    );

    assign seg = blank ? SEG_BLANK : w_decoded;

endmodule

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit0 = a ... bit6 = g.
module seven_seg_decoder
    import alu_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Hex glyph lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_display_scanner.sv
// Registered ALU result/flags with static per-digit and multiplexed
// scanned hex seven-segment outputs, with optional leading-zero blanking.
module alu_display_scanner
    import alu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [3:0]             alu_control,
    input  logic                   load,
    input  logic                   blank_lz,
    output logic [WIDTH-1:0]       result,
    output logic                   negative,
    output logic                   zero,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   result_valid,
    output logic [7*(WIDTH/4)-1:0] seg_static,
    output logic [6:0]             seg_scan,
    output logic [WIDTH/4-1:0]     digit_en
);

    localparam int DIGITS = WIDTH / 4;
    localparam int IDX_W  = digit_idx_width(DIGITS);
    localparam int PRE_W  = digit_idx_width(REFRESH_DIV);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("alu_display_scanner: WIDTH must be a positive multiple of 4");
    end
    if (REFRESH_DIV < 1) begin : g_bad_div
        $error("alu_display_scanner: REFRESH_DIV must be at least 1");
    end

    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_negative;
    logic             w_alu_zero;
    logic             w_alu_carry;
    logic             w_alu_overflow;

    logic [WIDTH-1:0] r_result;
    logic             r_negative;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_valid;
    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_digit_idx;

    logic [6:0]       w_seg_digit [DIGITS];

    arithmetic_logic_unit #(.WIDTH(WIDTH)) u_alu (
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .result      (w_alu_result),
        .negative    (w_alu_negative),
        .zero        (w_alu_zero),
        .carry_out   (w_alu_carry),
        .overflow    (w_alu_overflow)
    );

    // Result and flag capture on load; valid pulses the cycle after a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_negative <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (load) begin
                r_result   <= w_alu_result;
                r_negative <= w_alu_negative;
                r_zero     <= w_alu_zero;
                r_carry    <= w_alu_carry;
                r_overflow <= w_alu_overflow;
            end
            r_valid <= load;
        end
    end

    // Refresh prescaler and scan digit index; independent of capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_digit_idx <= '0;
        end else if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
            r_presc     <= '0;
            r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // A digit above the least significant is blank when it and everything above are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic w_blank;
        if (i == 0) begin : g_lsd
            assign w_blank = 1'b0;
        end else begin : g_upper
            assign w_blank = blank_lz & (r_result[WIDTH-1:4*i] == '0);
        end
        seg_digit_blanker u_blanker (
            .nibble (r_result[4*i+3:4*i]),
            .blank  (w_blank),
            .seg    (w_seg_digit[i])
        );
        assign seg_static[7*i+6:7*i] = w_seg_digit[i];
    end

    assign seg_scan     = w_seg_digit[r_digit_idx];
    assign digit_en     = ~(DIGITS'(1) << r_digit_idx);
    assign result       = r_result;
    assign negative     = r_negative;
    assign zero         = r_zero;
    assign carry_out    = r_carry;
    assign overflow     = r_overflow;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_alu_display_scanner.sv
// Directed bench: an 8-bit scanner with a short refresh period and a
// 16-bit scanner for wide blanking and back-to-back loads.
module tb_alu_display_scanner;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [6:0] BLK    = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [3:0]  op;
    logic        blank_lz;

    logic [7:0]  a8, b8, result8;
    logic        load8, neg8, zero8, carry8, ovf8, valid8;
    logic [13:0] segst8;
    logic [6:0]  segsc8;
    logic [1:0]  den8;

    logic [15:0] a16, b16, result16;
    logic        load16, neg16, zero16, carry16, ovf16, valid16;
    logic [27:0] segst16;
    logic [6:0]  segsc16;
    logic [3:0]  den16;

    int n_checks;
    int n_pass;

    alu_display_scanner #(.WIDTH(8), .REFRESH_DIV(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .alu_control(op),
        .load(load8), .blank_lz(blank_lz), .result(result8),
        .negative(neg8), .zero(zero8), .carry_out(carry8), .overflow(ovf8),
        .result_valid(valid8), .seg_static(segst8), .seg_scan(segsc8),
        .digit_en(den8)
    );

    alu_display_scanner #(.WIDTH(16), .REFRESH_DIV(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .alu_control(op),
        .load(load16), .blank_lz(blank_lz), .result(result16),
        .negative(neg16), .zero(zero16), .carry_out(carry16), .overflow(ovf16),
        .result_valid(valid16), .seg_static(segst16), .seg_scan(segsc16),
        .digit_en(den16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({result8, neg8, zero8, carry8, ovf8, valid8} !== 13'h0) begin
            $display("FAIL reset_regs8: got %h required 0", {result8, neg8, zero8, carry8, ovf8, valid8});
        end else n_pass++;
        n_checks++;
        if (den8 !== 2'b10 || segsc8 !== 7'b1000000) begin
            $display("FAIL reset_scan8: got en=%b seg=%b required en=10 seg=1000000", den8, segsc8);
        end else n_pass++;
        blank_lz = 1'b0;
        #1;
        n_checks++;
        if (segst8 !== {7'b1000000, 7'b1000000}) begin
            $display("FAIL reset_static_nolz: got %b required %b", segst8, {7'b1000000, 7'b1000000});
        end else n_pass++;
        blank_lz = 1'b1;
        #1;
        n_checks++;
        if (segst16 !== {BLK, BLK, BLK, 7'b1000000}) begin
            $display("FAIL reset_static16_lz: got %b required %b", segst16, {BLK, BLK, BLK, 7'b1000000});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h3C; b8 = 8'h05; op = OP_ADD; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        n_checks++;
        if (den8 !== 2'b01 || result8 !== 8'h41) begin
            $display("FAIL pre_reset_state: got en=%b res=%h required en=01 res=41", den8, result8);
        end else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({result8, neg8, zero8, carry8, ovf8, valid8} !== 13'h0) begin
            $display("FAIL async_reset_regs: got %h required 0", {result8, neg8, zero8, carry8, ovf8, valid8});
        end else n_pass++;
        n_checks++;
        if (den8 !== 2'b10 || segsc8 !== 7'b1000000) begin
            $display("FAIL async_reset_scan: got en=%b seg=%b required en=10 seg=1000000", den8, segsc8);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        blank_lz = 1'b0;
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h05; op = OP_ADD; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h41 || valid8 !== 1'b1) begin
            $display("FAIL add_result: got res=%h valid=%b required res=41 valid=1", result8, valid8);
        end else n_pass++;
        n_checks++;
        if ({neg8, zero8, carry8, ovf8} !== 4'b0000) begin
            $display("FAIL add_flags: got %b required 0000", {neg8, zero8, carry8, ovf8});
        end else n_pass++;
        n_checks++;
        if (segst8 !== {7'b0011001, 7'b1111001}) begin
            $display("FAIL add_segs: got %b required %b", segst8, {7'b0011001, 7'b1111001});
        end else n_pass++;
        blank_lz = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid8 !== 1'b0 || result8 !== 8'h41) begin
            $display("FAIL add_hold: got res=%h valid=%b required res=41 valid=0", result8, valid8);
        end else n_pass++;
        n_checks++;
        if (segst8 !== {7'b0011001, 7'b1111001}) begin
            $display("FAIL add_segs_lz: got %b required %b", segst8, {7'b0011001, 7'b1111001});
        end else n_pass++;
    endtask

    task automatic test_add_overflow;
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; op = OP_ADD; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h80 || {neg8, zero8, carry8, ovf8} !== 4'b1001) begin
            $display("FAIL add_ovf: got res=%h nzcv=%b required res=80 nzcv=1001", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h02; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h01 || {neg8, zero8, carry8, ovf8} !== 4'b0010) begin
            $display("FAIL add_carry: got res=%h nzcv=%b required res=01 nzcv=0010", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
    endtask

    task automatic test_sub_blank;
        blank_lz = 1'b1;
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h05; op = OP_SUB; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h00 || {neg8, zero8, carry8, ovf8} !== 4'b0110) begin
            $display("FAIL sub_zero: got res=%h nzcv=%b required res=00 nzcv=0110", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
        n_checks++;
        if (segst8 !== {BLK, 7'b1000000}) begin
            $display("FAIL sub_blank_segs: got %b required %b", segst8, {BLK, 7'b1000000});
        end else n_pass++;
        blank_lz = 1'b0;
        #1;
        n_checks++;
        if (segst8 !== {7'b1000000, 7'b1000000}) begin
            $display("FAIL sub_noblank_segs: got %b required %b", segst8, {7'b1000000, 7'b1000000});
        end else n_pass++;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'hFE || {neg8, zero8, carry8, ovf8} !== 4'b1000) begin
            $display("FAIL sub_borrow: got res=%h nzcv=%b required res=FE nzcv=1000", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h7F || {neg8, zero8, carry8, ovf8} !== 4'b0011) begin
            $display("FAIL sub_ovf: got res=%h nzcv=%b required res=7F nzcv=0011", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
    endtask

    task automatic test_logic_ops;
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h3C; op = OP_AND; load8 = 1'b1;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h30; op = OP_ORR;
        n_checks++;
        if (result8 !== 8'h30 || {neg8, zero8, carry8, ovf8} !== 4'b0000) begin
            $display("FAIL and_op: got res=%h nzcv=%b required res=30 nzcv=0000", result8, {neg8, zero8, carry8, ovf8});
        end else n_pass++;
        @(negedge clk);
        load8 = 1'b0;
        n_checks++;
        if (result8 !== 8'h3F || valid8 !== 1'b1) begin
            $display("FAIL orr_op: got res=%h valid=%b required res=3F valid=1", result8, valid8);
        end else n_pass++;
    endtask

    task automatic test_scan_phase;
        logic [7:0] exp_res;
        int idx;
        @(negedge clk);
        rst_n = 1'b0; blank_lz = 1'b0; load8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_res = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) exp_res = 8'hA5;
            idx = (k / 4) % 2;
            n_checks++;
            if (den8 !== ~(2'b01 << idx)) begin
                $display("FAIL scan_en k=%0d: got %b required %b", k, den8, ~(2'b01 << idx));
            end else n_pass++;
            n_checks++;
            if (segsc8 !== seg_of(exp_res[4*idx +: 4])) begin
                $display("FAIL scan_seg k=%0d: got %b required %b", k, segsc8, seg_of(exp_res[4*idx +: 4]));
            end else n_pass++;
            if (k == 7 || k == 8) begin
                n_checks++;
                if (valid8 !== (k == 7)) begin
                    $display("FAIL scan_valid k=%0d: got %b required %b", k, valid8, (k == 7));
                end else n_pass++;
            end
            if (k == 6) begin
                a8 = 8'hA5; b8 = 8'h00; op = OP_ADD; load8 = 1'b1;
            end else begin
                load8 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3];
        vals = '{16'h1234, 16'hBEEF, 16'h00A0};
        blank_lz = 1'b1;
        @(negedge clk);
        b16 = 16'h0000; op = OP_ADD; load16 = 1'b1; a16 = vals[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (result16 !== vals[i] || valid16 !== 1'b1) begin
                $display("FAIL b2b_%0d: got res=%h valid=%b required res=%h valid=1", i, result16, valid16, vals[i]);
            end else n_pass++;
            if (i < 2) a16 = vals[i+1];
            else load16 = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (valid16 !== 1'b0 || result16 !== 16'h00A0) begin
            $display("FAIL b2b_end: got res=%h valid=%b required res=00A0 valid=0", result16, valid16);
        end else n_pass++;
        n_checks++;
        if (segst16 !== {BLK, BLK, 7'b0001000, 7'b1000000}) begin
            $display("FAIL wide_blank: got %b required %b", segst16, {BLK, BLK, 7'b0001000, 7'b1000000});
        end else n_pass++;
        blank_lz = 1'b0;
        #1;
        n_checks++;
        if (segst16 !== {7'b1000000, 7'b1000000, 7'b0001000, 7'b1000000}) begin
            $display("FAIL wide_noblank: got %b required %b", segst16, {7'b1000000, 7'b1000000, 7'b0001000, 7'b1000000});
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; op = OP_ADD; blank_lz = 1'b0;
        a8 = '0; b8 = '0; load8 = 1'b0;
        a16 = '0; b16 = '0; load16 = 1'b0;
        test_reset();
        test_reset_mid_scan();
        test_add();
        test_add_overflow();
        test_sub_blank();
        test_logic_ops();
        test_scan_phase();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_display_scanner.md
Name: alu_display_scanner

Overview:
- Parametrised ALU result/flag register with a hex seven-segment front end, used on the board bring-up path.
- Operands are evaluated by the existing arithmetic_logic_unit #(WIDTH) and captured on a load strobe; registered flags are held for observation.
- The registered result is presented on two outputs: direct-drive per-digit segments, and a time-multiplexed single segment bus with a rotating digit enable.
- Optional leading-zero blanking is supported.

Parameters:
- WIDTH, 8, operand/result width; multiple of 4, >= 4
- DIGITS, WIDTH/4, hex digits displayed (derived, not overridden)
- REFRESH_DIV, 50000, clock cycles per scan digit; >= 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_control  in  4  ALU operation code (alu_pkg encodings)
- load  in  1  capture ALU result and flags at this clock edge
- blank_lz  in  1  1 = blank leading zero digits
- result  out  WIDTH  registered ALU result
- negative, zero, carry_out, overflow  out  1 each  registered flags
- result_valid  out  1  high the cycle after any load
- seg_static  out  7*DIGITS  per-digit segments, digit i at [7i+6:7i]
- seg_scan  out  7  segments of the currently scanned digit
- digit_en  out  DIGITS  one-hot, active-low scan enable

Behaviour:
- Clock domain and reset: one clock. Reset is asynchronous and active-low: rst_n low clears all state immediately, independent of clk.
- Segment encoding: active-low, bit0=a ... bit6=g. "0" = 7'b1000000; blank = 7'b1111111.
- Reset values: result=0, all flags=0, result_valid=0, prescaler=0, digit_idx=0. Consequently digit_en = ~1 (digit 0 on), seg_scan = "0", and every seg_static digit = "0" (digit 0 only when blank_lz=1; others blank).
- Capture, latency 1: on a rising edge with load=1, result and the flags take the combinational ALU outputs for the current a, b and alu_control; result_valid=1 in the following cycle.
  - load held high recaptures every cycle and keeps result_valid high.
  - load=0 holds result and flags, and result_valid=0.
- Reset mid-operation: a pending capture is discarded. load is ignored while rst_n=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_idx increments mod DIGITS (DIGITS-1 -> 0). With REFRESH_DIV=1, digit_idx advances every cycle.
- Scan outputs:
  - digit_en = ~(1 << digit_idx).
  - seg_scan = decode(result[4*digit_idx+3 : 4*digit_idx]), subject to blanking.
  - Both outputs are combinational from registers and are glitch-free per cycle.
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked iff result[WIDTH-1:4i]==0. Digit 0 is never blanked, so result 0 shows a single "0". Blanking applies to both seg_static and seg_scan. blank_lz is sampled combinationally.
- Flags: taken unmodified from the ALU. Carry follows the ARM convention: SUB carry=1 means no borrow.
- Scanning continues independently of load; capture never resets the scan position.
- Elaboration: assert WIDTH%4==0 and REFRESH_DIV>=1.

Decomposition:
- alu_pkg:
  - ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_ORR=4'b0011
  - SEG_BLANK=7'b1111111
  - function clog2-safe digit index width (min 1)
- Sub-module seg_digit_blanker: nibble + blank flag -> 7 segments. It wraps the existing seven_seg_decoder and is instantiated DIGITS times for seg_static.
- seg_scan is a mux of seg_static by digit_idx, so no extra decoder is needed.
- Prescaler and scan index stay inline.

Test Plan:
1. Reset mid-scan: rst_n=0 asynchronously at a non-zero prescaler -> result=0, flags=0, result_valid=0, digit_en=2'b10, seg_scan=7'b1000000 before the next clk edge.
2. WIDTH=8: a=8'h3C, b=8'h05, ALU_ADD, load 1 cycle -> next cycle result=8'h41, result_valid=1 for exactly one cycle. seg_static[13:7] = "4" (7'b0011001), seg_static[6:0] = "1" (7'b1111001).
3. a=8'h7F, b=8'h01, ALU_ADD -> result=8'h80, negative=1, overflow=1, carry_out=0, zero=0.
4. a=b=8'h05, ALU_SUB, blank_lz=1 -> result=0, zero=1, carry_out=1; digit 1 = 7'b1111111, digit 0 = 7'b1000000.
5. REFRESH_DIV=4, WIDTH=8: digit_en alternates 2'b10/2'b01 every 4 cycles. seg_scan tracks the selected nibble. A load mid-period does not disturb the scan phase.
6. WIDTH=16, load held 3 cycles with changing a -> result follows each cycle, result_valid high 3 consecutive cycles. With a=16'h00A0 and blank_lz=1: digits 3 and 2 blank, digit 1 = "A", digit 0 = "0".
